// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing generator for VGA-style displays.
// Produces the pixel column/line counters plus hsync, vsync, de and the
// line/frame start pulses, all registered together so they describe the
// same pixel in the same cycle.
// Optional feature: define VGA_TIMING_FRAME_CNT_EN to add the 16-bit
// frame_cnt output, which counts frame starts.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int XW       = 11,
  parameter int YW       = 10
) (
  input  logic          pixel_clk,
  input  logic          rst_n,
  input  logic          en,
  output logic [XW-1:0] counter_x,
  output logic [YW-1:0] counter_y,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic          line_start,
  output logic          frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [15:0]   frame_cnt
`endif
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  localparam logic [XW-1:0] X_LAST = XW'(H_TOTAL - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_TOTAL - 1);
  localparam logic          HS_ACT = (HS_POL != 0);
  localparam logic          VS_ACT = (VS_POL != 0);

  // Reject timings that cannot be represented or that would break the
  // reset-to-last-pixel scheme.
  if (H_BP < 1) begin : g_bad_hbp
    $error("vga_timing_gen: H_BP must be at least 1");
  end
  if (V_BP < 1) begin : g_bad_vbp
    $error("vga_timing_gen: V_BP must be at least 1");
  end
  if (64'(H_TOTAL) > (64'd1 << XW)) begin : g_bad_xw
    $error("vga_timing_gen: H_TOTAL does not fit in XW bits");
  end
  if (64'(V_TOTAL) > (64'd1 << YW)) begin : g_bad_yw
    $error("vga_timing_gen: V_TOTAL does not fit in YW bits");
  end

  logic [XW-1:0] x_nxt;
  logic [YW-1:0] y_nxt;
  logic          de_nxt;
  logic          hsync_nxt;
  logic          vsync_nxt;
  logic          line_nxt;
  logic          frame_nxt;

  // Next pixel position and the outputs that describe it; registering these
  // together keeps every output aligned with the counters.
  always_comb begin
    x_nxt = counter_x + XW'(1);
    y_nxt = counter_y;
    if (counter_x == X_LAST) begin
      x_nxt = '0;
      y_nxt = (counter_y == Y_LAST) ? '0 : counter_y + YW'(1);
    end
    de_nxt    = (int'(x_nxt) < H_ACTIVE) && (int'(y_nxt) < V_ACTIVE);
    hsync_nxt = ((int'(x_nxt) >= HS_START) && (int'(x_nxt) < HS_END)) ? HS_ACT : ~HS_ACT;
    // y only moves when x wraps, so vsync edges land on x = 0
    vsync_nxt = ((int'(y_nxt) >= VS_START) && (int'(y_nxt) < VS_END)) ? VS_ACT : ~VS_ACT;
    line_nxt  = (x_nxt == '0);
    frame_nxt = line_nxt && (y_nxt == '0);
  end

  // Timing registers: reset parks on the last pixel so the first enabled
  // edge lands on (0,0); a stalled cycle holds everything and drops pulses.
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      counter_x   <= X_LAST;
      counter_y   <= Y_LAST;
      de          <= 1'b0;
      hsync       <= ~HS_ACT;
      vsync       <= ~VS_ACT;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (en) begin
      counter_x   <= x_nxt;
      counter_y   <= y_nxt;
      de          <= de_nxt;
      hsync       <= hsync_nxt;
      vsync       <= vsync_nxt;
      line_start  <= line_nxt;
      frame_start <= frame_nxt;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  // Frame counter updates in the same cycle frame_start is shown; wraps
  // naturally at 16 bits.
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else if (en && frame_nxt) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen. A small-geometry instance (7x5 pixels,
// 35-cycle frame, active-high hsync, active-low vsync) exercises full frames,
// stalls and reset; a default-geometry instance covers the 800-pixel line.
// Expected values come from the count of enabled edges since reset.
module tb_vga_timing_gen;

  logic pixel_clk = 1'b0;
  logic rst_n = 1'b1;
  logic en = 1'b0;

  logic [10:0] s_x;
  logic [9:0]  s_y;
  logic        s_hs, s_vs, s_de, s_ls, s_fs;
  logic [10:0] d_x;
  logic [9:0]  d_y;
  logic        d_hs, d_vs, d_de, d_ls, d_fs;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] s_fc, d_fc;
`endif

  int total = 0;
  int passes = 0;
  int k = 0;
  bit en_last = 1'b0;

  always #5 pixel_clk = ~pixel_clk;

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1), .VS_POL(0), .XW(11), .YW(10)
  ) u_small (
    .pixel_clk(pixel_clk), .rst_n(rst_n), .en(en),
    .counter_x(s_x), .counter_y(s_y), .hsync(s_hs), .vsync(s_vs),
    .de(s_de), .line_start(s_ls), .frame_start(s_fs)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt(s_fc)
`endif
  );

  vga_timing_gen u_dflt (
    .pixel_clk(pixel_clk), .rst_n(rst_n), .en(en),
    .counter_x(d_x), .counter_y(d_y), .hsync(d_hs), .vsync(d_vs),
    .de(d_de), .line_start(d_ls), .frame_start(d_fs)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt(d_fc)
`endif
  );

  task automatic chk(input string tag, input longint obs, input longint exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      $display("FAIL %s observed=%0d expected=%0d at t=%0t", tag, obs, exp, $time);
      $error("check %s failed", tag);
    end
  endtask

  // Reset values, checked as literals.
  task automatic chk_reset();
    chk("rst_s_x", s_x, 6);
    chk("rst_s_y", s_y, 4);
    chk("rst_s_de", s_de, 0);
    chk("rst_s_hs", s_hs, 0);
    chk("rst_s_vs", s_vs, 1);
    chk("rst_s_ls", s_ls, 0);
    chk("rst_s_fs", s_fs, 0);
    chk("rst_d_x", d_x, 799);
    chk("rst_d_y", d_y, 524);
    chk("rst_d_hs", d_hs, 1);
    chk("rst_d_vs", d_vs, 1);
    chk("rst_d_de", d_de, 0);
`ifdef VGA_TIMING_FRAME_CNT_EN
    chk("rst_s_fc", s_fc, 0);
`endif
  endtask

  // Compare both instances against the pixel implied by k enabled edges.
  task automatic chk_model();
    int p, x, y, pd, xd, yd;
    bit pulse_ok;
    pulse_ok = en_last && (k >= 1);
    p = (k + 34) % 35;
    x = p % 7;
    y = p / 7;
    chk("s_x", s_x, x);
    chk("s_y", s_y, y);
    chk("s_de", s_de, (x < 4 && y < 2) ? 1 : 0);
    chk("s_hs", s_hs, (x == 5) ? 1 : 0);
    chk("s_vs", s_vs, (y == 3) ? 0 : 1);
    chk("s_ls", s_ls, (pulse_ok && x == 0) ? 1 : 0);
    chk("s_fs", s_fs, (pulse_ok && p == 0) ? 1 : 0);
`ifdef VGA_TIMING_FRAME_CNT_EN
    chk("s_fc", s_fc, (k >= 1) ? (((k - 1) / 35 + 1) % 65536) : 0);
`endif
    pd = (k + 419999) % 420000;
    xd = pd % 800;
    yd = pd / 800;
    chk("d_x", d_x, xd);
    chk("d_y", d_y, yd);
    chk("d_hs", d_hs, (xd >= 656 && xd < 752) ? 0 : 1);
    chk("d_vs", d_vs, (yd >= 490 && yd < 492) ? 0 : 1);
    chk("d_de", d_de, (xd < 640 && yd < 480) ? 1 : 0);
    chk("d_ls", d_ls, (pulse_ok && xd == 0) ? 1 : 0);
    chk("d_fs", d_fs, (pulse_ok && pd == 0) ? 1 : 0);
  endtask

  // One clock: update the edge count, then sample 1 time unit later.
  task automatic tick();
    @(posedge pixel_clk);
    if (!rst_n) k = 0;
    else if (en) k++;
    en_last = rst_n && en;
    #1;
    chk_model();
  endtask

  initial begin
    // Power-on reset (explicit falling edge of rst_n).
    #1 rst_n = 1'b0;
    #1 chk_reset();
    tick();
    tick();

    // Release; first enabled edge shows (0,0) with both pulses and de.
    rst_n = 1'b1;
    en = 1'b1;
    tick();
    chk("first_fs", s_fs, 1);
    chk("first_ls", s_ls, 1);
    chk("first_de", s_de, 1);

    // Pulse cycle followed by a stall: pulse drops and does not come back.
    en = 1'b0;
    tick();
    chk("stall_fs", s_fs, 0);
    chk("stall_x", s_x, 0);
    tick();
    en = 1'b1;
    tick();
    chk("resume_x", s_x, 1);
    chk("resume_fs", s_fs, 0);

    // Several full small frames with en held high.
    repeat (110) tick();

    // Random 50% enable over well beyond two small frames.
    repeat (200) begin
      en = 1'(($urandom_range(0, 1)));
      tick();
    end

    // Mid-frame asynchronous reset, between clock edges.
    en = 1'b1;
    repeat (17) tick();
    #3 rst_n = 1'b0;
    #1 chk_reset();
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_fs", s_fs, 1);
    chk("post_rst_dfs", d_fs, 1);

    // Long enabled run: default-geometry lines 0..2 (hsync window and
    // line_start every 800 cycles) plus many small frames.
    repeat (1700) tick();

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
- REQ-001: The block SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
- REQ-002: The block SHALL have parameters H_FP, H_SYNC and H_BP, defaults 16, 96 and 48: horizontal front porch, sync width and back porch, in pixels.
- REQ-003: The block SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
- REQ-004: The block SHALL have parameters V_FP, V_SYNC and V_BP, defaults 10, 2 and 33: vertical front porch, sync width and back porch, in lines.
- REQ-005: The block SHALL have parameters HS_POL and VS_POL, default 0 each, giving the active sync level (0 = active-low).
- REQ-006: The block SHALL have parameters XW and YW, defaults 11 and 10, giving the counter widths.
- REQ-007: Port pixel_clk SHALL be an input, 1 bit: the single clock, rising edge.
- REQ-008: Port rst_n SHALL be an input, 1 bit: asynchronous active-low reset.
- REQ-009: Port en SHALL be an input, 1 bit: pixel advance enable.
- REQ-010: Ports counter_x and counter_y SHALL be outputs, XW and YW bits: current pixel column and line.
- REQ-011: Ports hsync and vsync SHALL be outputs, 1 bit each, at the polarity set by HS_POL and VS_POL.
- REQ-012: Port de SHALL be an output, 1 bit: high when the current pixel is visible.
- REQ-013: Ports line_start and frame_start SHALL be outputs, 1 bit each: one-cycle pulses.

Function
- REQ-014: H_TOTAL SHALL equal H_ACTIVE+H_FP+H_SYNC+H_BP, and V_TOTAL SHALL equal V_ACTIVE+V_FP+V_SYNC+V_BP.
- REQ-015: The design SHALL require H_BP>=1, V_BP>=1 and H_TOTAL<=2^XW, V_TOTAL<=2^YW; a violation SHALL cause an elaboration error.
- REQ-016: On a rising edge with en=1, counter_x SHALL increment by 1; at H_TOTAL-1 it SHALL wrap to 0.
- REQ-017: counter_y SHALL increment only when counter_x wraps; at V_TOTAL-1 it SHALL wrap to 0 in that same cycle.
- REQ-018: When en=0, all counters, hsync, vsync and de SHALL hold their values, and line_start and frame_start SHALL be 0.
- REQ-019: All outputs SHALL be registered and describe the same pixel as the counter outputs in the same cycle, with zero skew between outputs.
- REQ-020: de SHALL be 1 exactly when counter_x<H_ACTIVE and counter_y<V_ACTIVE.
- REQ-021: hsync SHALL be at its active level exactly when H_ACTIVE+H_FP <= counter_x < H_ACTIVE+H_FP+H_SYNC, for every line.
- REQ-022: vsync SHALL be at its active level exactly when V_ACTIVE+V_FP <= counter_y < V_ACTIVE+V_FP+V_SYNC.
- REQ-023: vsync SHALL change only on a cycle where counter_x changes to 0.
- REQ-024: line_start SHALL be 1 for exactly one enabled cycle, the cycle in which counter_x first shows 0.
- REQ-025: frame_start SHALL be 1 for exactly one enabled cycle, the cycle in which (counter_x,counter_y) first shows (0,0); in that cycle line_start SHALL also be 1.
- REQ-026: A pulse cycle followed by en=0 SHALL drop the pulse; the pulse SHALL NOT reappear when en returns to 1.

Reset
- REQ-027: While rst_n=0, counter_x SHALL be H_TOTAL-1, counter_y SHALL be V_TOTAL-1, de SHALL be 0, hsync and vsync SHALL be at their inactive levels, and both pulses SHALL be 0.
- REQ-028: Reset SHALL act immediately, regardless of pixel_clk and in the middle of any line or frame.
- REQ-029: The first enabled edge after reset is released SHALL produce (0,0) with frame_start=1, line_start=1 and de=1.

Configuration
- REQ-030: With macro VGA_TIMING_FRAME_CNT_EN defined, the block SHALL add output port frame_cnt, 16 bits, reset to 0.
- REQ-031: With VGA_TIMING_FRAME_CNT_EN defined, frame_cnt SHALL increment in the same cycle that frame_start is 1 and SHALL wrap from 0xFFFF to 0.
- REQ-032: Without VGA_TIMING_FRAME_CNT_EN, port frame_cnt SHALL be absent, and all other behaviour SHALL be identical.

Verification
- REQ-033: Defaults, en=1, reset then run 420000 cycles (one full 800x525 frame = 420000 pixels) -> frame_start at cycle 1 and again at cycle 420001; exactly 307200 de=1 cycles in between.
- REQ-034: Defaults, line 0 -> hsync low for counter_x 656..751 (96 cycles) and high elsewhere; line_start pulses every 800 cycles.
- REQ-035: Defaults -> vsync low for counter_y 490..491 only, with edges coinciding with counter_x=0.
- REQ-036: Toggle en with a random 50% pattern over two frames -> sequence of counter and output values identical to the en=1 run with stalled cycles removed; no duplicated pulses.
- REQ-037: Assert rst_n at counter (300,200) mid-frame -> outputs reach the reset values immediately, without a clock edge; after release, frame_start on the first enabled edge.
- REQ-038: H_ACTIVE=4, H_FP=1, H_SYNC=1, H_BP=1, V_ACTIVE=2, V_FP=1, V_SYNC=1, V_BP=1, HS_POL=1, macro defined -> period 35 cycles; hsync high at x=5; frame_cnt=3 after 3 frames.
